control_fsm: RTL
================

// Module: control_fsm
// PURPOSE
//  Multi-cycle instruction decoder/sequencer for the Lapido datapath; parametrised successor of the single-cycle decoder.
//  Accepts instructions over a valid/ready handshake and decodes the class/function fields into registered datapath controls.
//  Holds memory ops until a memory acknowledge arrives, with a timeout. Flags illegal encodings instead of silently ignoring them.
// PARAMETERS
//  INSTR_W      32  instruction width (>=32); class=instruction[INSTR_W-1-:3], func=instruction[INSTR_W-4-:5]
//  MEM_TIMEOUT  15  max MEM_WAIT cycles without memAck before memFault (>=1)
//  CNT_W        16  width of performance counters (CTRL_PERF_EN only)
// PORTS
//  clock            in   1        rising-edge clock
//  reset            in   1        synchronous, active-high
//  instrValid       in   1        instruction present
//  instrReady       out  1        decoder can accept; transfer on instrValid&&instrReady at posedge
//  instruction      in   INSTR_W  instruction word
//  memAck           in   1        memory access complete (sampled in MEM_WAIT only)
//  branch, ALUSrc, regWrite, registerB, jumpRegister  out 1  datapath controls, active-high
//  memRead, memWrite out 1        active-LOW memory strobes
//  memToReg         out  2        00 ALU, 01 memory, 10 PC+1
//  ALUOp            out  5        ALU function
//  opcodeSignExtend out  2        00 plain, 01 high const, 10 low const
//  updateB          out  1        toggles once per accepted legal instruction
//  illegal, memFault out 1        one-cycle fault pulses
//  busy             out  1        state != IDLE
// BEHAVIOUR
//  Reset/defaults: state IDLE; controls = NOP set (branch/regWrite/registerB/jumpRegister/ALUSrc=0, memRead=memWrite=1,
//   memToReg=00, ALUOp=00000, opcodeSignExtend=00); updateB=0, illegal=memFault=0. Reset mid-op aborts, no writeback.
//  States: IDLE -> EXEC on transfer; EXEC: non-mem op -> IDLE, or stay EXEC if a new transfer occurs; mem op -> MEM_WAIT;
//   MEM_WAIT -> IDLE on memAck or timeout.
//  instrReady = (IDLE) | (EXEC & current op not memory). Latency: accept at edge N, controls valid cycle N+1 for one cycle
//   (non-mem), so back-to-back non-mem ops sustain 1/cycle. Controls return to NOP set in any cycle without a decoded op.
//  Decode (class:func):
//   001 ALU: ALUOp=func for func in {00000,00001,00011,00100,00101,00110,01000,01001,1xxxx}; regWrite=1; others illegal.
//   100 MEM: func[0]=0 load: ALUSrc=1, memRead=0 held EXEC..MEM_WAIT, memToReg=01, regWrite=1 only in cycle memAck=1.
//            func[0]=1 store: ALUSrc=1, registerB=1, memWrite=0 held EXEC..MEM_WAIT.
//   010 CONST: func[1:0] 00 loadlit ALUOp=10011; 01 lch ALUOp=01011 sext=01; 10 lcl ALUOp=01100 sext=10; all ALUSrc=1,
//            regWrite=1; 11 illegal.
//   000 NOP: ALUSrc=1, rest NOP set.
//   101 CTRL func[4:2]: 000 jump branch=1 ALUSrc=1 ALUOp=01010; 001 beq branch=1 registerB=1 ALUOp=00010;
//            010 bne as beq with ALUOp=00111; 011 jal branch=1 memToReg=10 regWrite=1; 100 jr branch=1 jumpRegister=1
//            ALUOp=10101; others illegal.
//   011/110/111: illegal.
//  Illegal: accepted, illegal=1 in EXEC cycle, controls NOP set, updateB not toggled, next state IDLE.
//  MEM_WAIT: wait counter starts at 0 on entry, +1 per cycle; memAck at counter<MEM_TIMEOUT completes (memAck in the
//   EXEC cycle itself is ignored). Counter==MEM_TIMEOUT without ack: memFault=1 one cycle, strobes released, regWrite never asserted.
//  memAck outside MEM_WAIT ignored. updateB toggles at the EXEC-entry edge.
// CONFIGURATION
//  CTRL_PERF_EN defined: extra outputs instrCount[CNT_W] (legal accepted instrs) and stallCount[CNT_W] (MEM_WAIT cycles),
//   both cleared by reset, saturating at all-ones. Undefined: ports absent, no counter logic.
// TESTING
//  Reset then add 0x20000000 valid one cycle -> next cycle regWrite=1 ALUOp=00000, updateB 0->1, instrReady=1 throughout.
//  Three back-to-back ALU ops (and, xor, or) -> ALUOp 10001,10110,10111 on consecutive cycles, no bubbles.
//  load 0x80000000, memAck after 3 MEM_WAIT cycles -> memRead=0 for 4 cycles, regWrite=1 only in ack cycle, then IDLE.
//  store, memAck never -> memWrite=0 until counter==15, memFault pulse, instrReady back next cycle.
//  class 110 and CTRL func 111 -> illegal pulse, NOP controls, updateB unchanged.
//  reset asserted during MEM_WAIT of a load -> next cycle IDLE, NOP set, regWrite never 1; with CTRL_PERF_EN counters =0.

Source files
------------

// File: rtl/control_fsm_if.sv
// control_fsm_if: instruction handshake, memory acknowledge and datapath control
// bundle for the Lapido decoder/sequencer.
// Optional build macro: CTRL_PERF_EN adds the instrCount/stallCount counters.
interface control_fsm_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned CNT_W   = 16
);
  // Instruction handshake and memory acknowledge
  logic               instrValid;
  logic               instrReady;
  logic [INSTR_W-1:0] instruction;
  logic               memAck;

  // Registered datapath controls (memRead/memWrite are active-low)
  logic               branch;
  logic               ALUSrc;
  logic               regWrite;
  logic               registerB;
  logic               jumpRegister;
  logic               memRead;
  logic               memWrite;
  logic [1:0]         memToReg;
  logic [4:0]         ALUOp;
  logic [1:0]         opcodeSignExtend;

  // Status
  logic               updateB;
  logic               illegal;
  logic               memFault;
  logic               busy;

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0]   instrCount;
  logic [CNT_W-1:0]   stallCount;

  modport master (
    output instrValid, instruction, memAck,
    input  instrReady, branch, ALUSrc, regWrite, registerB, jumpRegister,
           memRead, memWrite, memToReg, ALUOp, opcodeSignExtend,
           updateB, illegal, memFault, busy, instrCount, stallCount
  );

  modport slave (
    input  instrValid, instruction, memAck,
    output instrReady, branch, ALUSrc, regWrite, registerB, jumpRegister,
           memRead, memWrite, memToReg, ALUOp, opcodeSignExtend,
           updateB, illegal, memFault, busy, instrCount, stallCount
  );
`else
  // Counter width only matters when the counters are built in
  localparam int unsigned unused_cnt_w = CNT_W;

  modport master (
    output instrValid, instruction, memAck,
    input  instrReady, branch, ALUSrc, regWrite, registerB, jumpRegister,
           memRead, memWrite, memToReg, ALUOp, opcodeSignExtend,
           updateB, illegal, memFault, busy
  );

  modport slave (
    input  instrValid, instruction, memAck,
    output instrReady, branch, ALUSrc, regWrite, registerB, jumpRegister,
           memRead, memWrite, memToReg, ALUOp, opcodeSignExtend,
           updateB, illegal, memFault, busy
  );
`endif
endinterface

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle instruction decoder/sequencer for the Lapido datapath.
// Instructions arrive over a valid/ready handshake; class/function fields are decoded
// into registered controls one cycle after acceptance. Memory ops hold their strobes
// until memAck or a MEM_TIMEOUT-cycle timeout. Illegal encodings raise a one-cycle pulse.
// Optional build macro: CTRL_PERF_EN adds saturating instrCount/stallCount outputs.
module control_fsm #(
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic         clock,
  input  logic         reset,
  control_fsm_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic       branch;
    logic       alu_src;
    logic       reg_write;
    logic       register_b;
    logic       jump_register;
    logic       mem_read_n;
    logic       mem_write_n;
    logic [1:0] mem_to_reg;
    logic [4:0] alu_op;
    logic [1:0] sext;
  } ctrl_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  legal;
    logic  is_mem;
    logic  is_load;
  } dec_t;

  localparam ctrl_t NOP_CTRL = '{
    branch:        1'b0,
    alu_src:       1'b0,
    reg_write:     1'b0,
    register_b:    1'b0,
    jump_register: 1'b0,
    mem_read_n:    1'b1,
    mem_write_n:   1'b1,
    mem_to_reg:    2'b00,
    alu_op:        5'b00000,
    sext:          2'b00
  };

  // Pure decode of class/function; illegal encodings leave the NOP control set.
  // Load writeback (regWrite) is not part of the decode: it is raised only in the ack cycle.
  function automatic dec_t decode(input logic [2:0] cls, input logic [4:0] func);
    dec_t d;
    d.ctrl    = NOP_CTRL;
    d.legal   = 1'b0;
    d.is_mem  = 1'b0;
    d.is_load = 1'b0;
    case (cls)
      3'b000: begin
        d.legal        = 1'b1;
        d.ctrl.alu_src = 1'b1;
      end
      3'b001: begin
        case (func)
          5'b00000, 5'b00001, 5'b00011, 5'b00100,
          5'b00101, 5'b00110, 5'b01000, 5'b01001: d.legal = 1'b1;
          default:                                d.legal = func[4];
        endcase
        if (d.legal) begin
          d.ctrl.alu_op    = func;
          d.ctrl.reg_write = 1'b1;
        end else begin
          d.ctrl = NOP_CTRL;
        end
      end
      3'b010: begin
        d.legal          = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.reg_write = 1'b1;
        case (func[1:0])
          2'b00: d.ctrl.alu_op = 5'b10011;
          2'b01: begin
            d.ctrl.alu_op = 5'b01011;
            d.ctrl.sext   = 2'b01;
          end
          2'b10: begin
            d.ctrl.alu_op = 5'b01100;
            d.ctrl.sext   = 2'b10;
          end
          default: begin
            d.legal = 1'b0;
            d.ctrl  = NOP_CTRL;
          end
        endcase
      end
      3'b100: begin
        d.legal        = 1'b1;
        d.is_mem       = 1'b1;
        d.ctrl.alu_src = 1'b1;
        if (!func[0]) begin
          d.is_load         = 1'b1;
          d.ctrl.mem_read_n = 1'b0;
          d.ctrl.mem_to_reg = 2'b01;
        end else begin
          d.ctrl.register_b  = 1'b1;
          d.ctrl.mem_write_n = 1'b0;
        end
      end
      3'b101: begin
        d.legal       = 1'b1;
        d.ctrl.branch = 1'b1;
        case (func[4:2])
          3'b000: begin
            d.ctrl.alu_src = 1'b1;
            d.ctrl.alu_op  = 5'b01010;
          end
          3'b001: begin
            d.ctrl.register_b = 1'b1;
            d.ctrl.alu_op     = 5'b00010;
          end
          3'b010: begin
            d.ctrl.register_b = 1'b1;
            d.ctrl.alu_op     = 5'b00111;
          end
          3'b011: begin
            d.ctrl.mem_to_reg = 2'b10;
            d.ctrl.reg_write  = 1'b1;
          end
          3'b100: begin
            d.ctrl.jump_register = 1'b1;
            d.ctrl.alu_op        = 5'b10101;
          end
          default: begin
            d.legal = 1'b0;
            d.ctrl  = NOP_CTRL;
          end
        endcase
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  state_e            state_q;
  ctrl_t             ctrl_q;
  logic              is_mem_q;
  logic              is_load_q;
  logic [WAIT_W-1:0] wait_q;
  logic              upd_q;
  logic              illegal_q;
  logic              fault_q;
  logic              ready_q;
  logic              busy_q;

  dec_t              dec_s;
  logic              xfer_s;
  logic              timeout_s;
  logic              go_idle_s;
  logic              load_ack_s;
  logic              unused_s;

  assign dec_s      = decode(bus.instruction[INSTR_W-1 -: 3], bus.instruction[INSTR_W-4 -: 5]);
  assign xfer_s     = bus.instrValid & ready_q;
  assign timeout_s  = (state_q == MEM_WAIT) & (wait_q == WAIT_LAST);
  assign go_idle_s  = ((state_q == EXEC) & ~is_mem_q) |
                      ((state_q == MEM_WAIT) & (timeout_s | bus.memAck));
  // A load writes back only in the cycle its acknowledge arrives in time; reset aborts it
  assign load_ack_s = ~reset & (state_q == MEM_WAIT) & is_load_q & bus.memAck & ~timeout_s;
  assign unused_s   = ^bus.instruction[INSTR_W-9:0];

  // Sequencer state, wait counter and registered controls/status
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ctrl_q    <= NOP_CTRL;
      is_mem_q  <= 1'b0;
      is_load_q <= 1'b0;
      wait_q    <= '0;
      upd_q     <= 1'b0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      if (xfer_s) begin
        state_q   <= EXEC;
        busy_q    <= 1'b1;
        wait_q    <= '0;
        illegal_q <= ~dec_s.legal;
        if (dec_s.legal) begin
          ctrl_q    <= dec_s.ctrl;
          is_mem_q  <= dec_s.is_mem;
          is_load_q <= dec_s.is_load;
          ready_q   <= ~dec_s.is_mem;
          upd_q     <= ~upd_q;
        end else begin
          ctrl_q    <= NOP_CTRL;
          is_mem_q  <= 1'b0;
          is_load_q <= 1'b0;
          ready_q   <= 1'b1;
        end
      end else if (go_idle_s) begin
        state_q   <= IDLE;
        ctrl_q    <= NOP_CTRL;
        is_mem_q  <= 1'b0;
        is_load_q <= 1'b0;
        ready_q   <= 1'b1;
        busy_q    <= 1'b0;
        fault_q   <= timeout_s;
      end else if (state_q == EXEC) begin
        // Memory op: strobes stay asserted while waiting for the acknowledge
        state_q <= MEM_WAIT;
        wait_q  <= '0;
      end else if (state_q == MEM_WAIT) begin
        wait_q <= wait_q + WAIT_W'(1);
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign bus.instrReady       = ready_q;
  assign bus.branch           = ctrl_q.branch;
  assign bus.ALUSrc           = ctrl_q.alu_src;
  assign bus.regWrite         = ctrl_q.reg_write | load_ack_s;
  assign bus.registerB        = ctrl_q.register_b;
  assign bus.jumpRegister     = ctrl_q.jump_register;
  assign bus.memRead          = ctrl_q.mem_read_n;
  assign bus.memWrite         = ctrl_q.mem_write_n;
  assign bus.memToReg         = ctrl_q.mem_to_reg;
  assign bus.ALUOp            = ctrl_q.alu_op;
  assign bus.opcodeSignExtend = ctrl_q.sext;
  assign bus.updateB          = upd_q;
  assign bus.illegal          = illegal_q;
  assign bus.memFault         = fault_q;
  assign bus.busy             = busy_q;

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] instr_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating counts of legal accepted instructions and MEM_WAIT cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (xfer_s && dec_s.legal && (instr_cnt_q != '1)) begin
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end else begin
        instr_cnt_q <= instr_cnt_q;
      end
      if ((state_q == MEM_WAIT) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
    end
  end

  assign bus.instrCount = instr_cnt_q;
  assign bus.stallCount = stall_cnt_q;
`else
  // Counter width only matters when the counters are built in
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule
